// File: rtl/universal_shift_register.sv
// Parametrised shift/rotate register with parallel load, serial ports and an N-step burst engine.
// One-edge latency for load/shift. No backpressure: Shift_Enable and Burst_Start are dropped while Busy.
module universal_shift_register #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Parallel_In,
    input  logic             Load,
    input  logic [2:0]       Mode,
    input  logic             Shift_Enable,
    input  logic             Shift_In_Left,
    input  logic             Shift_In_Right,
    input  logic             Burst_Start,
    input  logic [CW-1:0]    Burst_Count,
    output logic [WIDTH-1:0] Reg_Content,
    output logic             Shift_Out_Left,
    output logic             Shift_Out_Right,
    output logic             Busy,
    output logic             Done
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [2:0] MD_SLL = 3'b001;
    localparam logic [2:0] MD_SRL = 3'b010;
    localparam logic [2:0] MD_ROL = 3'b011;
    localparam logic [2:0] MD_ROR = 3'b100;
    localparam logic [2:0] MD_ASR = 3'b101;

    logic [WIDTH-1:0] r_q;
    logic [0:0]       r_state;
    logic [2:0]       r_mode;
    logic [CW-1:0]    r_cnt;
    logic             r_done;

    // Codes 000, 110 and 111 all hold.
    function automatic logic [WIDTH-1:0] f_shift(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] r,
        input logic             sil,
        input logic             sir
    );
        case (m)
            MD_SLL:  f_shift = {r[WIDTH-2:0], sil};
            MD_SRL:  f_shift = {sir, r[WIDTH-1:1]};
            MD_ROL:  f_shift = {r[WIDTH-2:0], r[WIDTH-1]};
            MD_ROR:  f_shift = {r[0], r[WIDTH-1:1]};
            MD_ASR:  f_shift = {r[WIDTH-1], r[WIDTH-1:1]};
            default: f_shift = r;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_q     <= '0;
            r_state <= ST_IDLE;
            r_mode  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (Load) begin
                // Load also aborts a running burst without signalling completion.
                r_q     <= Parallel_In;
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else if (r_state == ST_BURST) begin
                r_q   <= f_shift(r_mode, r_q, Shift_In_Left, Shift_In_Right);
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
            end else if (Burst_Start) begin
                if (Burst_Count != '0) begin
                    r_mode  <= Mode;
                    r_cnt   <= Burst_Count;
                    r_state <= ST_BURST;
                end else begin
                    r_done <= 1'b1;
                end
            end else if (Shift_Enable) begin
                r_q <= f_shift(Mode, r_q, Shift_In_Left, Shift_In_Right);
            end
        end
    end

    logic w_busy;
    assign w_busy          = (r_state == ST_BURST);
    assign Reg_Content     = r_q;
    assign Shift_Out_Left  = r_q[WIDTH-1];
    assign Shift_Out_Right = r_q[0];
    assign Busy            = w_busy;
    assign Done            = r_done;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed and randomized checks of universal_shift_register (WIDTH=8) against an arithmetic model.
module tb_universal_shift_register;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          CLK = 1'b0;
    logic          Reset, Load, Shift_Enable, Shift_In_Left, Shift_In_Right, Burst_Start;
    logic [W-1:0]  Parallel_In;
    logic [2:0]    Mode;
    logic [CW-1:0] Burst_Count;
    logic [W-1:0]  Reg_Content;
    logic          Shift_Out_Left, Shift_Out_Right, Busy, Done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_q, m_rem, m_mode, m_busy, m_done;

    universal_shift_register #(.WIDTH(W)) dut (
        .CLK(CLK), .Reset(Reset), .Parallel_In(Parallel_In), .Load(Load), .Mode(Mode),
        .Shift_Enable(Shift_Enable), .Shift_In_Left(Shift_In_Left), .Shift_In_Right(Shift_In_Right),
        .Burst_Start(Burst_Start), .Burst_Count(Burst_Count), .Reg_Content(Reg_Content),
        .Shift_Out_Left(Shift_Out_Left), .Shift_Out_Right(Shift_Out_Right), .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    function automatic int apply(input int m, input int r, input int sil, input int sir);
        case (m)
            1:       return (r * 2 + sil) % 256;
            2:       return r / 2 + sir * 128;
            3:       return (r * 2) % 256 + r / 128;
            4:       return r / 2 + (r % 2) * 128;
            5:       return r / 2 + (r / 128) * 128;
            default: return r;
        endcase
    endfunction

    // Advance one edge, update the model from the inputs seen at that edge, then settle.
    task automatic tick();
        int nd;
        @(posedge CLK);
        nd = 0;
        if (Reset) begin
            m_q = 0; m_busy = 0; m_rem = 0;
        end else if (Load) begin
            m_q = int'(Parallel_In); m_busy = 0;
        end else if (m_busy != 0) begin
            m_q = apply(m_mode, m_q, int'(Shift_In_Left), int'(Shift_In_Right));
            m_rem = m_rem - 1;
            if (m_rem == 0) begin m_busy = 0; nd = 1; end
        end else if (Burst_Start) begin
            if (Burst_Count == 0) nd = 1;
            else begin m_busy = 1; m_rem = int'(Burst_Count); m_mode = int'(Mode); end
        end else if (Shift_Enable) begin
            m_q = apply(int'(Mode), m_q, int'(Shift_In_Left), int'(Shift_In_Right));
        end
        m_done = nd;
        #1;
    endtask

    task automatic quiet();
        Reset = 0; Load = 0; Shift_Enable = 0; Burst_Start = 0; Burst_Count = '0;
        Mode = 3'd0; Shift_In_Left = 0; Shift_In_Right = 0; Parallel_In = '0;
    endtask

    task automatic load(input logic [W-1:0] v);
        Load = 1; Parallel_In = v; tick(); Load = 0;
    endtask

    task automatic test_reset();
        quiet(); Reset = 1; tick(); tick(); Reset = 0;
        n_vec++;
        if (Reg_Content !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0) begin
            n_err++;
            $display("FAIL reset: reg=%h busy=%b done=%b, required reg=00 busy=0 done=0", Reg_Content, Busy, Done);
        end
    endtask

    task automatic test_load();
        load(8'hA5);
        n_vec++;
        if (Reg_Content !== 8'hA5 || Busy !== 1'b0 || Done !== 1'b0 ||
            Shift_Out_Left !== 1'b1 || Shift_Out_Right !== 1'b1) begin
            n_err++;
            $display("FAIL load: reg=%h busy=%b done=%b sol=%b sor=%b, required A5 0 0 1 1",
                     Reg_Content, Busy, Done, Shift_Out_Left, Shift_Out_Right);
        end
    endtask

    task automatic test_single_modes();
        logic [2:0] modes [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        logic [7:0] exps  [6] = '{8'h4A, 8'hD2, 8'h4B, 8'hD2, 8'hD2, 8'hA5};
        for (int i = 0; i < 6; i++) begin
            load(8'hA5);
            Mode = modes[i]; Shift_In_Left = 0; Shift_In_Right = 1; Shift_Enable = 1;
            tick();
            Shift_Enable = 0;
            n_vec++;
            if (Reg_Content !== exps[i] || Reg_Content !== 8'(m_q)) begin
                n_err++;
                $display("FAIL single_mode%0d: reg=%h, required %h", modes[i], Reg_Content, exps[i]);
            end
        end
        quiet();
    endtask

    task automatic test_burst_rol();
        logic [7:0] exps [3] = '{8'h03, 8'h06, 8'h0C};
        load(8'h81);
        Mode = 3'd3; Burst_Count = CW'(3); Burst_Start = 1;
        tick();
        Burst_Start = 0;
        n_vec++;
        if (Busy !== 1'b1 || Reg_Content !== 8'h81 || Done !== 1'b0) begin
            n_err++;
            $display("FAIL burst_start: busy=%b reg=%h done=%b, required 1 81 0", Busy, Reg_Content, Done);
        end
        for (int i = 0; i < 3; i++) begin
            Mode = 3'($urandom_range(0, 7)); Shift_Enable = 1'($urandom_range(0, 1));
            tick();
            n_vec++;
            if (Reg_Content !== exps[i] || Busy !== (i < 2) || Done !== (i == 2)) begin
                n_err++;
                $display("FAIL burst_rol step%0d: reg=%h busy=%b done=%b, required %h %b %b",
                         i, Reg_Content, Busy, Done, exps[i], (i < 2), (i == 2));
            end
        end
        quiet();
        tick();
        n_vec++;
        if (Done !== 1'b0 || Reg_Content !== 8'h0C) begin
            n_err++;
            $display("FAIL burst_rol after: done=%b reg=%h, required 0 0C", Done, Reg_Content);
        end
    endtask

    task automatic test_burst_zero();
        load(8'h5A);
        Mode = 3'd1; Burst_Count = '0; Burst_Start = 1;
        tick();
        quiet();
        n_vec++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Reg_Content !== 8'h5A) begin
            n_err++;
            $display("FAIL burst_zero: done=%b busy=%b reg=%h, required 1 0 5A", Done, Busy, Reg_Content);
        end
        tick();
        n_vec++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL burst_zero after: done=%b busy=%b, required 0 0", Done, Busy);
        end
    endtask

    task automatic test_abort();
        int seen_done;
        for (int k = 0; k < 2; k++) begin
            seen_done = 0;
            load(8'hF0);
            Mode = 3'd2; Burst_Count = CW'(8); Burst_Start = 1; Shift_In_Right = 1;
            tick();
            Burst_Start = 0;
            tick(); seen_done |= int'(Done);
            tick(); seen_done |= int'(Done);
            if (k == 0) begin Load = 1; Parallel_In = 8'h3C; end
            else Reset = 1;
            tick(); seen_done |= int'(Done);
            quiet();
            tick(); seen_done |= int'(Done);
            n_vec++;
            if ((k == 0 && Reg_Content !== 8'h3C) || (k == 1 && Reg_Content !== 8'h00) ||
                Busy !== 1'b0 || seen_done != 0) begin
                n_err++;
                $display("FAIL abort_%s: reg=%h busy=%b done_seen=%0d, required %h 0 0",
                         (k == 0) ? "load" : "reset", Reg_Content, Busy, seen_done, (k == 0) ? 8'h3C : 8'h00);
            end
        end
    endtask

    task automatic test_serial();
        logic [7:0] bits = 8'b1011_0010;
        load(8'h00);
        Mode = 3'd1; Burst_Count = CW'(8); Burst_Start = 1;
        tick();
        Burst_Start = 0;
        for (int i = 7; i >= 0; i--) begin
            Shift_In_Left = bits[i];
            tick();
        end
        n_vec++;
        if (Reg_Content !== 8'hB2 || Done !== 1'b1 || Busy !== 1'b0 || Shift_Out_Left !== 1'b1) begin
            n_err++;
            $display("FAIL serial: reg=%h done=%b busy=%b sol=%b, required B2 1 0 1",
                     Reg_Content, Done, Busy, Shift_Out_Left);
        end
        quiet();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Reset          = ($urandom_range(0, 99) < 2);
            Load           = ($urandom_range(0, 99) < 6);
            Parallel_In    = 8'($urandom);
            Mode           = 3'($urandom_range(0, 7));
            Shift_Enable   = 1'($urandom_range(0, 1));
            Shift_In_Left  = 1'($urandom_range(0, 1));
            Shift_In_Right = 1'($urandom_range(0, 1));
            Burst_Start    = ($urandom_range(0, 99) < 15);
            Burst_Count    = CW'($urandom_range(0, 15));
            tick();
            n_vec++;
            if (Reg_Content !== 8'(m_q) || Busy !== (m_busy != 0) || Done !== (m_done != 0) ||
                Shift_Out_Left !== (m_q >= 128) || Shift_Out_Right !== (m_q % 2 == 1)) begin
                n_err++;
                $display("FAIL random cyc%0d: reg=%h busy=%b done=%b, required %h %0d %0d",
                         i, Reg_Content, Busy, Done, 8'(m_q), m_busy, m_done);
            end
        end
        quiet();
    endtask

    initial begin
        m_q = 0; m_rem = 0; m_mode = 0; m_busy = 0; m_done = 0;
        quiet();
        test_reset();
        test_load();
        test_single_modes();
        test_burst_rol();
        test_burst_zero();
        test_abort();
        test_serial();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
